// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the frame FSM encoding and the error-counter width/saturation helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        CAPTURE = 2'b10
    } state_t;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] sat_inc(
        input logic [ERR_W-1:0] v
    );
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with zero-latency head output and extra-MSB pointers.
// Ports: clk/rst_n, clear, push/push_data/wr_ok, pop, valid/head, full.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             wr_ok
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             rd_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = !empty;

    // A pop on a full FIFO frees the slot the same cycle; an empty FIFO
    // never pops, so push+pop on empty is push-only.
    assign rd_ok = pop && !empty && !clear;
    assign wr_ok = push && (!full || rd_ok) && !clear;

    assign head = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ONE;
            if (rd_ok) rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, frame capture FSM,
// receive FIFO, sticky overflow and saturating error count.
// Ports: rx_clk/rx_reset, enable, div, sample_tick, rx_ready/rx_error/rx_data,
//        rd_valid/rd_data/rd_ready, overflow, err_count, clear.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic             rx_clk,
    input  logic             rx_reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             sample_tick,
    input  logic             rx_ready,
    input  logic             rx_error,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rd_valid,
    output logic [WIDTH:0]   rd_data,
    input  logic             rd_ready,
    output logic             overflow,
    output logic [ERR_W-1:0] err_count,
    input  logic             clear
);

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic             tick_q;

    // >= rather than == so a shrunk divisor wraps on the next cycle.
    assign cnt_nxt = (cnt >= div) ? '0 : cnt + DIV_W'(1);

    always_ff @(posedge rx_clk or negedge rx_reset) begin
        if (!rx_reset) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (!enable) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            tick_q <= (cnt_nxt == div);
        end
    end

    assign sample_tick = tick_q && enable;

    // ---------------- frame FSM ----------------
    state_t         state;
    state_t         state_nxt;
    logic           rdy_q;
    logic           armed;
    logic           rise;
    logic           fall;
    logic           push;
    logic           cap_en;
    logic [WIDTH:0] cap_q;

    // armed blocks a rx_ready level that was already high across reset
    // from looking like a fresh rise.
    assign rise = rx_ready && !rdy_q && armed;
    assign fall = !rx_ready && rdy_q;

    always_ff @(posedge rx_clk or negedge rx_reset) begin
        if (!rx_reset) begin
            state <= IDLE;
            rdy_q <= 1'b0;
            armed <= 1'b0;
            cap_q <= '0;
        end else begin
            state <= enable ? state_nxt : IDLE;
            rdy_q <= rx_ready;
            if (!rx_ready) armed <= 1'b1;
            if (cap_en) cap_q <= {rx_error, rx_data};
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rise) state_nxt = BUSY;
            BUSY:    if (fall) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push   = (state == CAPTURE) && enable;
        cap_en = (state == BUSY) && fall;
    end

    // ---------------- FIFO and status ----------------
    logic wr_ok;
    logic full;

    uart_sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (rx_clk),
        .rst_n     (rx_reset),
        .clear     (clear),
        .push      (push),
        .push_data (cap_q),
        .pop       (rd_ready),
        .valid     (rd_valid),
        .head      (rd_data),
        .full      (full),
        .wr_ok     (wr_ok)
    );

    always_ff @(posedge rx_clk or negedge rx_reset) begin
        if (!rx_reset) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (push && !wr_ok && full) overflow <= 1'b1;
            if (wr_ok && cap_q[WIDTH]) err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
// Frames are modelled in a queue as they are sent and compared on each pop.
module tb_uart_rx_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [DIV_W-1:0] div;
    logic             sample_tick;
    logic             rx_ready;
    logic             rx_error;
    logic [WIDTH-1:0] rx_data;
    logic             rd_valid;
    logic [WIDTH:0]   rd_data;
    logic             rd_ready;
    logic             overflow;
    logic [7:0]       err_count;
    logic             clear;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH:0] q[$];
    logic           exp_ovf;
    int             exp_err;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .rx_clk      (clk),
        .rx_reset    (rst_n),
        .enable      (enable),
        .div         (div),
        .sample_tick (sample_tick),
        .rx_ready    (rx_ready),
        .rx_error    (rx_error),
        .rx_data     (rx_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .overflow    (overflow),
        .err_count   (err_count),
        .clear       (clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic e,
                              input int hi, input bit pop_cap,
                              input bit clr_cap);
        logic [WIDTH:0] h;
        rx_ready = 1'b1;
        rx_data  = 8'($urandom);
        rx_error = 1'($urandom);
        repeat (hi) @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = d;
        rx_error = e;
        @(negedge clk);
        chk("cap_lat", rd_valid, q.size() > 0);
        rx_data  = ~d;
        rx_error = ~e;
        if (clr_cap) begin
            clear = 1'b1;
            q.delete();
            exp_ovf = 1'b0;
            exp_err = 0;
        end else begin
            if (pop_cap) begin
                rd_ready = 1'b1;
                if (q.size() > 0) begin
                    h = q.pop_front();
                    chk("pop_cap_data", rd_data, h);
                end
            end
            if (q.size() < DEPTH) begin
                q.push_back({e, d});
                if (e && exp_err < 255) exp_err++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(negedge clk);
        rd_ready = 1'b0;
        clear    = 1'b0;
        chk("overflow", overflow, exp_ovf);
        chk("err_count", err_count, exp_err);
    endtask

    task automatic pop_check();
        logic [WIDTH:0] h;
        chk("pop_valid", rd_valid, 1'b1);
        if (q.size() > 0) begin
            h = q.pop_front();
            chk("pop_data", rd_data, h);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        exp_err = 0;
        chk("clr_valid", rd_valid, 1'b0);
        chk("clr_err", err_count, 8'd0);
        chk("clr_ovf", overflow, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] d;
        rst_n    = 1'b0;
        enable   = 1'b0;
        div      = 16'd3;
        rx_ready = 1'b0;
        rx_error = 1'b0;
        rx_data  = '0;
        rd_ready = 1'b0;
        clear    = 1'b0;
        exp_ovf  = 1'b0;
        exp_err  = 0;

        repeat (3) @(negedge clk);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, 9'h000);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_err", err_count, 8'd0);
        chk("rst_tick", sample_tick, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("tick_disabled", sample_tick, 1'b0);

        // div=3: ticks on clocks 3, 7, 11 after enable
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("tick_div3", sample_tick, (k % 4) == 3);
        end
        div = 16'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tick_div0", sample_tick, 1'b1);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("tick_off", sample_tick, 1'b0);

        // shrinking div below the running count wraps next cycle
        div    = 16'd7;
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("tick_div7", sample_tick, 1'b0);
        end
        div = 16'd2;
        for (int k = 6; k <= 9; k++) begin
            @(negedge clk);
            chk("tick_shrink", sample_tick, k == 8);
        end
        div = 16'd3;

        // basic capture, two cycles after the fall
        send_frame(8'hA5, 1'b0, 16, 1'b0, 1'b0);
        chk("cap_valid", rd_valid, 1'b1);
        chk("cap_data", rd_data, 9'h0A5);
        pop_check();
        chk("cap_drain", rd_valid, 1'b0);

        // push and pop together on an empty FIFO: push only
        send_frame(8'h3C, 1'b0, 4, 1'b1, 1'b0);
        chk("emp_pp_valid", rd_valid, 1'b1);
        pop_check();

        // overflow: five frames, no pops
        for (int i = 0; i < 5; i++)
            send_frame(8'h10 + 8'(i), 1'(i), 3, 1'b0, 1'b0);
        chk("ovf_flag", overflow, 1'b1);
        for (int i = 0; i < 4; i++) pop_check();
        chk("ovf_drain", rd_valid, 1'b0);
        do_clear();

        // full FIFO: capture with a same-cycle pop is accepted
        for (int i = 0; i < 4; i++)
            send_frame(8'h40 + 8'(i), 1'b0, 3, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 3, 1'b1, 1'b0);
        chk("full_pp_ovf", overflow, 1'b0);
        for (int i = 0; i < 4; i++) pop_check();
        chk("full_pp_drain", rd_valid, 1'b0);

        // clear beats a same-cycle capture
        send_frame(8'h66, 1'b1, 3, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 3, 1'b0, 1'b1);
        chk("clr_cap_valid", rd_valid, 1'b0);

        // error frames: count saturates at 255
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 2, 1'b0, 1'b0);
            pop_check();
        end
        chk("err_sat", err_count, 8'd255);
        send_frame(8'h99, 1'b1, 2, 1'b0, 1'b0);
        chk("err_hold", err_count, 8'd255);
        do_clear();

        // reset during BUSY discards the frame
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", rd_valid, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_nocap", rd_valid, 1'b0);
        chk("mid_rst_err", err_count, 8'd0);
        send_frame(8'h5A, 1'b0, 5, 1'b0, 1'b0);
        pop_check();
        chk("post_rst_drain", rd_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: frame data width, matching the receiver's data_out.
REQ-002 The block SHALL have parameter DEPTH, default 4 (power of two, >=2): number of receive FIFO entries.
REQ-003 The block SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-004 The block SHALL have port rx_clk  in  1: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rx_reset  in  1: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable  in  1: high = controller running; low = tick generator held and no captures.
REQ-007 The block SHALL have port div  in  DIV_W: oversample divisor; tick period = div+1 clocks.
REQ-008 The block SHALL have port sample_tick  out  1: one-cycle 16x-oversample enable pulse for the receiver.
REQ-009 The block SHALL have port rx_ready  in  1: receiver frame-finish indication, high for a multi-cycle window.
REQ-010 The block SHALL have port rx_error  in  1: receiver parity/stop error, valid in the cycle rx_ready falls.
REQ-011 The block SHALL have port rx_data  in  WIDTH: receiver data, valid in the cycle rx_ready falls.
REQ-012 The block SHALL have port rd_valid  out  1: FIFO non-empty.
REQ-013 The block SHALL have port rd_data  out  WIDTH+1: {error bit, data} of the head entry.
REQ-014 The block SHALL have port rd_ready  in  1: consumer pop; a pop occurs when rd_valid && rd_ready.
REQ-015 The block SHALL have port overflow  out  1: sticky; a frame was dropped because the FIFO was full.
REQ-016 The block SHALL have port err_count  out  8: saturating count of frames captured with error=1.
REQ-017 The block SHALL have port clear  in  1: synchronous clear of overflow, err_count and FIFO contents.

Function
REQ-018 The tick counter SHALL count 0..div, pulse sample_tick for exactly one cycle when it equals div, then wrap to 0; div=0 gives a tick every cycle.
REQ-019 A change of div mid-count SHALL take effect at the next wrap; if the counter already exceeds the new div, it SHALL wrap on the next cycle.
REQ-020 With enable low, the tick counter SHALL be held at 0, sample_tick SHALL be 0, and the FSM SHALL be forced to IDLE.
REQ-021 The frame FSM SHALL have three states: IDLE -> BUSY on rx_ready 0->1 (registered previous value); BUSY -> CAPTURE on rx_ready 1->0; CAPTURE -> IDLE unconditionally after one cycle.
REQ-022 In the cycle the FSM is in CAPTURE, the block SHALL write {rx_error, rx_data} from the falling-edge cycle, held in a register, into the FIFO.
REQ-023 A capture into a full FIFO SHALL drop the frame and set overflow, unless a pop occurs in the same cycle; in that case the write SHALL succeed.
REQ-024 A simultaneous push and pop on an empty FIFO SHALL push only; rd_valid SHALL rise in the next cycle, with no bypass.
REQ-025 Read latency SHALL be zero: rd_data SHALL show the head entry combinationally from the registered array.
REQ-026 Pointers SHALL be log2(DEPTH)+1 bits wide; full = MSBs differ and low bits are equal; empty = pointers are equal.
REQ-027 err_count SHALL increment on each accepted capture with error=1 and SHALL saturate at 255; dropped frames SHALL not be counted.
REQ-028 clear SHALL have priority over a same-cycle capture or pop: pointers go to 0, overflow and err_count go to 0, and the capture is discarded.

Reset
REQ-029 On rx_reset low, the block SHALL asynchronously set: FSM = IDLE; tick counter = 0; sample_tick = 0; pointers = 0 (rd_valid = 0); rd_data = 0; overflow = 0; err_count = 0; rx_ready history = 0.
REQ-030 A reset mid-frame SHALL discard the frame in progress; after release, the next rx_ready rise SHALL be required before any capture.

Structure
REQ-031 FSM state encodings (IDLE=2'b00, BUSY=2'b01, CAPTURE=2'b10) and the err_count width SHALL live in shared package uart_pkg.
REQ-032 The FIFO SHALL be a separate sub-module, uart_sync_fifo, parameterised by width and depth; tick generation and the FSM SHALL stay in uart_rx_ctrl.

Verification
REQ-033 Tick test: div=3, enable=1 -> sample_tick high on clocks 3, 7, 11 after enable; div=0 -> high every cycle.
REQ-034 Capture test: rx_ready high 16 cycles with rx_data=0xA5 and rx_error=0 at the fall -> rd_valid=1 two cycles after the fall, rd_data=9'h0A5.
REQ-035 Overflow test: 5 frames with no pops, DEPTH=4 -> 4 entries held, overflow=1, and pops return frames 1-4 in order.
REQ-036 Error test: 300 frames with rx_error=1, popping continuously -> err_count=255 saturated; clear -> err_count=0, rd_valid=0.
REQ-037 Reset test: assert rx_reset while in BUSY, then release and drop rx_ready -> no capture and rd_valid stays 0.
REQ-038 Full-FIFO simultaneous test: FIFO full, capture and pop in the same cycle -> write accepted, count stays 4, overflow stays 0.
